grf_wb_queue: RTL and testbench
===============================

Name: grf_wb_queue

Overview:
- Write-back buffer that drives the GRF write port (RegWrite/WA/WD/PC).
- Accepts register-write requests from the datapath and multi-cycle units, holds them in an in-order FIFO, and retires at most one per cycle into the GRF.
- Provides a combinational lookup port so the forwarding logic can read the youngest pending value for a register before it reaches the GRF.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears the queue.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; equals !full.
- in_wa  in  5  destination register.
- in_wd  in  32  write data.
- in_pc  in  32  PC of the producing instruction, used only for the GRF trace.
- hold  in  1  when 1, no retire this cycle.
- RegWrite  out  1  GRF write enable.
- WA  out  5  GRF write address.
- WD  out  32  GRF write data.
- PC  out  32  PC passed to the GRF for its $display trace.
- q_addr  in  5  lookup register number.
- q_hit  out  1  a pending entry matches q_addr.
- q_data  out  32  data of the youngest matching pending entry.
- count  out  AW+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Storage: circular FIFO. Each entry holds wa, wd and pc. The FIFO has a head pointer, a tail pointer and a count, all AW+1 bits. Pointers wrap modulo DEPTH.
- Push condition: in_valid && in_ready at the rising edge.
  - If in_wa != 0, the entry is written at tail, tail increments and count increments.
  - If in_wa == 0, the handshake completes but nothing is stored and the count is unchanged.
- Retire condition: RegWrite = !empty && !hold && !reset.
  - WA, WD and PC show the head entry combinationally.
  - At the rising edge where RegWrite = 1, head increments and count decrements.
  - When empty, WA = 0, WD = 0 and PC = 0.
- Latency: a request pushed at edge N is visible at the head no earlier than the cycle after N. There is no same-cycle pass-through from in_* to the GRF port.
- Simultaneous push and retire: both take effect and count is unchanged.
  - When full with a retire in the same cycle, in_ready is still 0. There is no push-on-pop while full.
- Ordering: strictly FIFO. Multiple pending writes to the same register retire oldest first, so the GRF ends with the youngest value.
- Lookup (combinational):
  - Searches all occupied entries for wa == q_addr. The youngest match, nearest the tail, wins.
  - q_addr == 0 always gives q_hit = 0 and q_data = 0.
  - No match gives q_hit = 0 and q_data = 0.
  - The lookup ignores the same-cycle in_* request.
  - The head entry retiring this cycle is still reported as a hit in that cycle.
- Reset:
  - At a rising edge with reset = 1: head, tail and count go to 0, and all pending entries are discarded without being written to the GRF.
  - RegWrite is 0 throughout any cycle in which reset = 1, including when reset arrives mid-drain.
  - After reset: in_ready = 1, empty = 1, full = 0, count = 0, q_hit = 0, and WA, WD and PC are 0.
- Pointer arithmetic: the index is the low AW bits. full/empty come from count, never from pointer equality alone.

Test Plan:
- Reset then single push (wa=5, wd=0x1234, pc=0x3000) -> next cycle RegWrite=1, WA=5, WD=0x00001234, PC=0x00003000; following cycle empty=1, RegWrite=0.
- Push wa=0, wd=0xFFFFFFFF -> in_ready=1 during the handshake, count stays 0, RegWrite never asserts.
- hold=1 while pushing 4 writes (wa=1..4) -> full=1, in_ready=0, count=4. A 5th request stalls (not accepted). Release hold -> retires in order wa=1,2,3,4 on consecutive cycles, then the stalled 5th.
- With hold=1, push wa=7 wd=0xA then wa=7 wd=0xB -> q_addr=7 gives q_hit=1, q_data=0xB. Release hold -> GRF sees 0xA then 0xB.
- Push and retire in the same cycle over 10 cycles with wrap-around (DEPTH=4) -> count constant, data order preserved across the pointer wrap.
- Fill 3 entries, assert reset for 1 cycle mid-drain -> RegWrite=0 in the reset cycle, count=0 afterwards, and no further GRF writes occur.

Source files
------------

// File: rtl/grf_wb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : grf_wb_queue_if
//  Brief    : Request, GRF write-port and forwarding-lookup bundle of the
//             GRF write-back queue.
//  Revision : 1.0
// ============================================================================
interface grf_wb_queue_if #(
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_wa;
    logic [31:0]   in_wd;
    logic [31:0]   in_pc;
    logic          hold;
    logic          RegWrite;
    logic [4:0]    WA;
    logic [31:0]   WD;
    logic [31:0]   PC;
    logic [4:0]    q_addr;
    logic          q_hit;
    logic [31:0]   q_data;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    modport slave (
        input  in_valid, in_wa, in_wd, in_pc, hold, q_addr,
        output in_ready, RegWrite, WA, WD, PC, q_hit, q_data, count, empty, full
    );

    modport master (
        output in_valid, in_wa, in_wd, in_pc, hold, q_addr,
        input  in_ready, RegWrite, WA, WD, PC, q_hit, q_data, count, empty, full
    );
endinterface
`default_nettype wire

// File: rtl/grf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : grf_wb_queue
//  Brief    : In-order write-back FIFO feeding the GRF write port, with a
//             youngest-match forwarding lookup over pending entries.
//  Revision : 1.0
// ============================================================================
module grf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    grf_wb_queue_if.slave      bus
);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [4:0]  r_wa_mem [DEPTH];
    logic [31:0] r_wd_mem [DEPTH];
    logic [31:0] r_pc_mem [DEPTH];

    logic [AW:0] r_head;
    logic [AW:0] r_tail;
    logic [AW:0] r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_in_ready;
    logic        w_push_hs;
    logic        w_store;
    logic        w_retire;
    logic        w_hit;
    logic [31:0] w_qdata;
    logic [AW-1:0] w_head_idx;
    logic [AW-1:0] w_tail_idx;

    assign w_head_idx = r_head[AW-1:0];
    assign w_tail_idx = r_tail[AW-1:0];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    assign w_in_ready = !w_full;
    assign w_push_hs  = bus.in_valid && w_in_ready;
    // Writes to r0 complete the handshake but are dropped.
    assign w_store    = w_push_hs && (bus.in_wa != 5'd0);
    assign w_retire   = !w_empty && !bus.hold && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_store) - (AW+1)'(w_retire);
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_wa_mem[w_tail_idx] <= bus.in_wa;
            r_wd_mem[w_tail_idx] <= bus.in_wd;
            r_pc_mem[w_tail_idx] <= bus.in_pc;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_hit   = 1'b0;
        w_qdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < r_count) && (bus.q_addr != 5'd0) &&
                (r_wa_mem[w_head_idx + AW'(i)] == bus.q_addr)) begin
                w_hit   = 1'b1;
                w_qdata = r_wd_mem[w_head_idx + AW'(i)];
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.RegWrite = w_retire;
    assign bus.WA       = w_empty ? 5'd0  : r_wa_mem[w_head_idx];
    assign bus.WD       = w_empty ? 32'd0 : r_wd_mem[w_head_idx];
    assign bus.PC       = w_empty ? 32'd0 : r_pc_mem[w_head_idx];
    assign bus.q_hit    = w_hit;
    assign bus.q_data   = w_qdata;
    assign bus.count    = r_count;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
endmodule
`default_nettype wire

// File: tb/tb_grf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grf_wb_queue
//  Brief    : Directed self-checking bench for grf_wb_queue.
//  Revision : 1.0
// ============================================================================
module tb_grf_wb_queue;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    grf_wb_queue_if #(.AW(2)) bus ();

    grf_wb_queue #(.DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_wa = 5'd0; bus.in_wd = 32'd0; bus.in_pc = 32'd0;
        bus.hold = 1'b0; bus.q_addr = 5'd5;
        tick(); tick();
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got=%b exp=0", bus.RegWrite); end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.empty, bus.full, bus.count, bus.q_hit} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_flags got rdy=%b emp=%b full=%b cnt=%0d hit=%b", bus.in_ready, bus.empty, bus.full, bus.count, bus.q_hit);
        end
        checks++;
        if ({bus.WA, bus.WD, bus.PC} !== {5'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL rst_port got WA=%0d WD=%h PC=%h exp zeros", bus.WA, bus.WD, bus.PC);
        end
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1; bus.in_wa = 5'd5; bus.in_wd = 32'h1234; bus.in_pc = 32'h3000;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL single_pre got RegWrite=%b rdy=%b exp 0/1", bus.RegWrite, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.RegWrite, bus.WA, bus.WD, bus.PC} !== {1'b1, 5'd5, 32'h00001234, 32'h00003000}) begin
            errors++; $display("FAIL single_retire got RW=%b WA=%0d WD=%h PC=%h", bus.RegWrite, bus.WA, bus.WD, bus.PC);
        end
        tick();
        checks++;
        if (bus.empty !== 1'b1 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL single_after got empty=%b RW=%b exp 1/0", bus.empty, bus.RegWrite);
        end
    endtask

    task automatic test_zero_reg();
        bus.in_valid = 1'b1; bus.in_wa = 5'd0; bus.in_wd = 32'hFFFFFFFF; bus.in_pc = 32'h4000;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL zero_count got cnt=%0d RW=%b exp 0/0", bus.count, bus.RegWrite);
        end
        tick();
        checks++;
        if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL zero_noretire got RW=%b exp=0", bus.RegWrite); end
    endtask

    task automatic test_full_hold();
        logic [4:0]  exp_wa [5];
        logic [31:0] exp_wd [5];
        logic        acc;
        exp_wa = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
        exp_wd = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h99};
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_wa = 5'(i); bus.in_wd = 32'(i * 'h11); bus.in_pc = 32'(i * 'h100);
            tick();
        end
        bus.in_wa = 5'd9; bus.in_wd = 32'h99; bus.in_pc = 32'h900;
        #1;
        checks++;
        if ({bus.full, bus.in_ready, bus.count} !== {1'b1, 1'b0, 3'd4}) begin
            errors++; $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp 1/0/4", bus.full, bus.in_ready, bus.count);
        end
        tick();
        checks++;
        if (bus.count !== 3'd4 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL full_stall got cnt=%0d RW=%b exp 4/0", bus.count, bus.RegWrite);
        end
        bus.hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.RegWrite !== 1'b1 || bus.WA !== exp_wa[k] || bus.WD !== exp_wd[k]) begin
                errors++;
                $display("FAIL drain_order[%0d] got RW=%b WA=%0d WD=%h exp RW=1 WA=%0d WD=%h",
                         k, bus.RegWrite, bus.WA, bus.WD, exp_wa[k], exp_wd[k]);
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL drain_done got empty=%b RW=%b exp 1/0", bus.empty, bus.RegWrite);
        end
    endtask

    task automatic test_lookup();
        logic [31:0] exp_wd [3];
        exp_wd = '{32'hA, 32'hB, 32'hC};
        bus.hold = 1'b1;
        bus.in_valid = 1'b1; bus.in_wa = 5'd7; bus.in_wd = 32'hA; bus.in_pc = 32'h10; tick();
        bus.in_wa = 5'd7; bus.in_wd = 32'hB; bus.in_pc = 32'h14; tick();
        bus.in_wa = 5'd3; bus.in_wd = 32'hC; bus.in_pc = 32'h18; tick();
        bus.in_valid = 1'b1; bus.in_wa = 5'd9; bus.in_wd = 32'hDEAD;
        bus.q_addr = 5'd9;
        #1;
        checks++;
        if (bus.q_hit !== 1'b0 || bus.q_data !== 32'd0) begin
            errors++; $display("FAIL lookup_inflight got hit=%b data=%h exp 0/0", bus.q_hit, bus.q_data);
        end
        bus.in_valid = 1'b0;
        bus.q_addr = 5'd7;
        #1;
        checks++;
        if (bus.q_hit !== 1'b1 || bus.q_data !== 32'hB) begin
            errors++; $display("FAIL lookup_youngest got hit=%b data=%h exp 1/0000000b", bus.q_hit, bus.q_data);
        end
        bus.q_addr = 5'd0;
        #1;
        checks++;
        if (bus.q_hit !== 1'b0 || bus.q_data !== 32'd0) begin
            errors++; $display("FAIL lookup_r0 got hit=%b data=%h exp 0/0", bus.q_hit, bus.q_data);
        end
        bus.q_addr = 5'd3;
        bus.hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.RegWrite !== 1'b1 || bus.WD !== exp_wd[k]) begin
                errors++; $display("FAIL lookup_drain[%0d] got RW=%b WD=%h exp 1/%h", k, bus.RegWrite, bus.WD, exp_wd[k]);
            end
            if (k == 2) begin
                checks++;
                if (bus.q_hit !== 1'b1 || bus.q_data !== 32'hC) begin
                    errors++; $display("FAIL lookup_retiring_head got hit=%b data=%h exp 1/0000000c", bus.q_hit, bus.q_data);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (bus.q_hit !== 1'b0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL lookup_after got hit=%b empty=%b exp 0/1", bus.q_hit, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  q_wa [$];
        logic [31:0] q_wd [$];
        bus.hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_wa = 5'(10 + i); bus.in_wd = 32'hB000_0000 + 32'(i); bus.in_pc = 32'h0;
            q_wa.push_back(5'(10 + i)); q_wd.push_back(32'hB000_0000 + 32'(i));
            tick();
        end
        bus.hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1; bus.in_wa = 5'(12 + k); bus.in_wd = 32'hC000_0000 + 32'(k); bus.in_pc = 32'(k);
            #1;
            checks++;
            if (bus.count !== 3'd2 || bus.RegWrite !== 1'b1 || bus.WA !== q_wa[0] || bus.WD !== q_wd[0]) begin
                errors++;
                $display("FAIL b2b[%0d] got cnt=%0d RW=%b WA=%0d WD=%h exp cnt=2 RW=1 WA=%0d WD=%h",
                         k, bus.count, bus.RegWrite, bus.WA, bus.WD, q_wa[0], q_wd[0]);
            end
            void'(q_wa.pop_front()); void'(q_wd.pop_front());
            q_wa.push_back(5'(12 + k)); q_wd.push_back(32'hC000_0000 + 32'(k));
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_drain got empty=%b exp=1", bus.empty); end
    endtask

    task automatic test_reset_mid_drain();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_wa = 5'(20 + i); bus.in_wd = 32'(i); bus.in_pc = 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WA !== 5'd20) begin
            errors++; $display("FAIL mid_first got RW=%b WA=%0d exp 1/20", bus.RegWrite, bus.WA);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL mid_reset_rw got=%b exp=0", bus.RegWrite); end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL mid_count got cnt=%0d empty=%b exp 0/1", bus.count, bus.empty);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL mid_nowrite[%0d] got RW=%b exp=0", k, bus.RegWrite); end
            tick();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_zero_reg();
        test_full_hold();
        test_lookup();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached before end of tests");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
